// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: FSM states, opcodes,
// ALU operation codes and datapath select codes.
package mc_pkg;

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECR    = 4'd7,
    S_EXECI    = 4'd8,
    S_ALUWB    = 4'd9,
    S_BRANCH   = 4'd10,
    S_JALRADR  = 4'd11,
    S_JAL      = 4'd12,
    S_LUI      = 4'd13,
    S_TRAP     = 4'd14
  } state_t;

  // Class of ALU work a state asks for; alu_decoder refines it with funct fields.
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'd0,
    ALUOP_SUB   = 2'd1,
    ALUOP_RTYPE = 2'd2,
    ALUOP_ITYPE = 2'd3
  } alu_op_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_WD   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  function automatic logic [2:0] imm_src_of(input logic [6:0] opcode);
    case (opcode)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      OP_LUI:    return IMM_U;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation select: the FSM gives the class of operation and
// funct3/funct7b5 pick the exact R-type or I-type function.
module alu_decoder
  import mc_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [3:0] alu_control
);

  logic is_reg;

  assign is_reg = (alu_op == ALUOP_RTYPE);

  // Immediate forms carry imm[10] in bit 30, so only SRAI may look at funct7b5.
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_RTYPE, ALUOP_ITYPE: begin
        case (funct3)
          3'b000:  alu_control = (is_reg && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control = ALU_SLL;
          3'b010:  alu_control = ALU_SLT;
          3'b011:  alu_control = ALU_SLTU;
          3'b100:  alu_control = ALU_XOR;
          3'b101:  alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_control = ALU_OR;
          default: alu_control = ALU_AND;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore FSM sequencing RV32I instructions over a shared-ALU, unified-memory
// datapath, with a req/ready memory handshake bounded by a wait timeout.
module multicycle_control_unit
  import mc_pkg::*;
#(
  parameter int HANDSHAKE       = 1,
  parameter int MAX_WAIT        = 255,
  parameter int TRAP_ON_ILLEGAL = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUControl,
  output logic [2:0] ImmSrc,
  output logic       Illegal,
  output logic       Timeout,
  output logic [3:0] State
);

  localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

  state_t        state_q, state_d;
  state_t        decode_next;
  logic          decode_bad;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          illegal_q, illegal_d;
  logic          timeout_q, timeout_d;
  logic          ready;
  logic          mem_wait_state;
  logic          wait_expired;
  alu_op_t       alu_op;

  assign ready          = (HANDSHAKE != 0) ? MemReady : 1'b1;
  assign mem_wait_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                          (state_q == S_MEMWRITE);
  // Expires on the cycle that would bring the wait count up to MAX_WAIT.
  assign wait_expired   = (MAX_WAIT != 0) && mem_wait_state && !ready &&
                          (wait_cnt_q == CNT_LAST);

  always_comb begin
    decode_next = S_FETCH;
    decode_bad  = 1'b0;
    case (op)
      OP_LOAD, OP_STORE: decode_next = S_MEMADR;
      OP_RTYPE:          decode_next = S_EXECR;
      OP_IMM:            decode_next = S_EXECI;
      OP_BRANCH: begin
        decode_next = S_BRANCH;
        decode_bad  = (funct3 != 3'b000) && (funct3 != 3'b001);
      end
      OP_JAL:            decode_next = S_JAL;
      OP_JALR:           decode_next = S_JALRADR;
      OP_LUI:            decode_next = S_LUI;
      default:           decode_bad  = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        if (ready) begin
          state_d = S_DECODE;
        end else if (wait_expired) begin
          state_d   = S_TRAP;
          timeout_d = 1'b1;
        end
      end
      S_DECODE: begin
        if (!decode_bad) begin
          state_d = decode_next;
        end else if (TRAP_ON_ILLEGAL != 0) begin
          state_d   = S_TRAP;
          illegal_d = 1'b1;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEMADR: state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: begin
        if (ready) begin
          state_d = S_MEMWB;
        end else if (wait_expired) begin
          state_d   = S_TRAP;
          timeout_d = 1'b1;
        end
      end
      S_MEMWB: state_d = S_FETCH;
      S_MEMWRITE: begin
        if (ready) begin
          state_d = S_FETCH;
        end else if (wait_expired) begin
          state_d   = S_TRAP;
          timeout_d = 1'b1;
        end
      end
      S_EXECR, S_EXECI: state_d = S_ALUWB;
      S_ALUWB:          state_d = S_FETCH;
      S_BRANCH:         state_d = S_FETCH;
      S_JALRADR:        state_d = S_JAL;
      S_JAL:            state_d = S_ALUWB;
      S_LUI:            state_d = S_ALUWB;
      S_TRAP:           state_d = S_TRAP;
      default:          state_d = S_RESET;
    endcase
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_d != state_q) begin
      wait_cnt_d = '0;
    end else if (mem_wait_state && !ready && (wait_cnt_q != '1)) begin
      wait_cnt_d = wait_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= S_RESET;
      wait_cnt_q <= '0;
      illegal_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      illegal_q  <= illegal_d;
      timeout_q  <= timeout_d;
    end
  end

  // Moore outputs: everything but the ready/Zero-qualified strobes comes from state.
  always_comb begin
    MemReq    = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_WD;
    alu_op    = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        MemReq    = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        IRWrite   = ready;
        PCWrite   = ready;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: begin
        MemReq = 1'b1;
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        MemReq   = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_WD;
        alu_op  = ALUOP_RTYPE;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_ITYPE;
      end
      S_ALUWB: RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_WD;
        alu_op  = ALUOP_SUB;
        case (funct3)
          3'b000:  PCWrite = Zero;
          3'b001:  PCWrite = !Zero;
          default: PCWrite = 1'b0;
        endcase
      end
      S_JALRADR: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
      end
      S_JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        PCWrite = 1'b1;
      end
      S_LUI: begin
        ALUSrcA = SRCA_ZERO;
        ALUSrcB = SRCB_IMM;
      end
      default: ;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .alu_control (ALUControl)
  );

  assign ImmSrc  = imm_src_of(op);
  assign Illegal = illegal_q;
  assign Timeout = timeout_q;
  assign State   = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: each step queues its expected
// outputs and the check pops and compares them a moment later.
module tb_multicycle_control_unit;
  import mc_pkg::*;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [6:0] op = OP_RTYPE;
  logic [2:0] funct3 = 3'b000;
  logic       funct7b5 = 1'b0;
  logic       Zero = 1'b0;
  logic       MemReady = 1'b0;
  logic       MemReq, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [3:0] ALUControl;
  logic [2:0] ImmSrc;
  logic       Illegal, Timeout;
  logic [3:0] State;

  typedef struct {
    string       tag;
    logic [3:0]  st;
    logic [15:0] ctl;
    logic [2:0]  imm;
    logic        ill;
    logic        tmo;
  } exp_t;

  exp_t       sbq[$];
  int         checks = 0;
  int         failures = 0;
  logic [2:0] exp_imm = 3'b000;

  always #5 CLK = ~CLK;

  multicycle_control_unit #(
    .HANDSHAKE       (1),
    .MAX_WAIT        (4),
    .TRAP_ON_ILLEGAL (1)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .Zero       (Zero),
    .MemReady   (MemReady),
    .MemReq     (MemReq),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .PCWrite    (PCWrite),
    .RegWrite   (RegWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUControl (ALUControl),
    .ImmSrc     (ImmSrc),
    .Illegal    (Illegal),
    .Timeout    (Timeout),
    .State      (State)
  );

  // Packs {MemReq,AdrSrc,MemWrite,IRWrite,PCWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUControl}.
  function automatic logic [15:0] ctl(input logic mr, input logic as, input logic mw,
                                      input logic iw, input logic pw, input logic rw,
                                      input logic [1:0] rs, input logic [1:0] sa,
                                      input logic [1:0] sb, input logic [3:0] alu);
    return {mr, as, mw, iw, pw, rw, rs, sa, sb, alu};
  endfunction

  task automatic setInstr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                          input logic [2:0] imm);
    op       = o;
    funct3   = f3;
    funct7b5 = f7;
    exp_imm  = imm;
  endtask

  task automatic applyStimulus(input string tag, input logic rdy, input logic z,
                               input state_t st, input logic [15:0] c,
                               input logic ill, input logic tmo);
    exp_t e;
    MemReady = rdy;
    Zero     = z;
    e.tag = tag;
    e.st  = st;
    e.ctl = c;
    e.imm = exp_imm;
    e.ill = ill;
    e.tmo = tmo;
    sbq.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t        e;
    logic [15:0] obs;
    checks++;
    assert (sbq.size() != 0) else begin
      failures++;
      $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
    end
    if (sbq.size() != 0) begin
      e   = sbq.pop_front();
      obs = {MemReq, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite,
             ResultSrc, ALUSrcA, ALUSrcB, ALUControl};
      checks++;
      assert (State === e.st) else begin
        failures++;
        $error("[TB] FAIL %s_state observed=%0d expected=%0d", e.tag, State, e.st);
      end
      checks++;
      assert (obs === e.ctl) else begin
        failures++;
        $error("[TB] FAIL %s_ctl observed=%b expected=%b", e.tag, obs, e.ctl);
      end
      checks++;
      assert (ImmSrc === e.imm) else begin
        failures++;
        $error("[TB] FAIL %s_imm observed=%b expected=%b", e.tag, ImmSrc, e.imm);
      end
      checks++;
      assert ({Illegal, Timeout} === {e.ill, e.tmo}) else begin
        failures++;
        $error("[TB] FAIL %s_flags observed=%b expected=%b", e.tag,
               {Illegal, Timeout}, {e.ill, e.tmo});
      end
    end
  endtask

  // One clock cycle: drive at the falling edge, check 1 time unit later, advance.
  task automatic step(input string tag, input logic rdy, input logic z, input state_t st,
                      input logic [15:0] c, input logic ill, input logic tmo);
    applyStimulus(tag, rdy, z, st, c, ill, tmo);
    #1;
    checkOutput();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic fetchDecode(input string tag);
    step({tag, "_fetch"}, 1'b1, 1'b0, S_FETCH,
         ctl(1, 0, 0, 1, 1, 0, 2'b10, 2'b00, 2'b10, 4'b0000), 1'b0, 1'b0);
    step({tag, "_decode"}, 1'b1, 1'b0, S_DECODE,
         ctl(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 4'b0000), 1'b0, 1'b0);
  endtask

  // Drops RST between clock edges, checks the asynchronous effect, then releases.
  task automatic pulseReset(input string tag);
    #2;
    RST = 1'b0;
    #1;
    applyStimulus({tag, "_async"}, 1'b0, 1'b0, S_RESET, 16'h0000, 1'b0, 1'b0);
    checkOutput();
    @(negedge CLK);
    RST = 1'b1;
    step({tag, "_release"}, 1'b0, 1'b0, S_RESET, 16'h0000, 1'b0, 1'b0);
  endtask

  initial begin
    setInstr(OP_RTYPE, 3'b000, 1'b0, 3'b000);
    #2;
    applyStimulus("reset", 1'b1, 1'b0, S_RESET, 16'h0000, 1'b0, 1'b0);
    checkOutput();
    @(negedge CLK);
    RST = 1'b1;
    step("rst_release", 1'b1, 1'b0, S_RESET, 16'h0000, 1'b0, 1'b0);

    fetchDecode("add");
    step("add_execr", 1'b1, 1'b0, S_EXECR, ctl(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 4'b0000), 1'b0, 1'b0);
    step("add_aluwb", 1'b1, 1'b0, S_ALUWB, ctl(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 4'b0000), 1'b0, 1'b0);

    setInstr(OP_RTYPE, 3'b000, 1'b1, 3'b000);
    fetchDecode("sub");
    step("sub_execr", 1'b1, 1'b0, S_EXECR, ctl(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 4'b0001), 1'b0, 1'b0);
    step("sub_aluwb", 1'b1, 1'b0, S_ALUWB, ctl(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 4'b0000), 1'b0, 1'b0);

    setInstr(OP_RTYPE, 3'b011, 1'b0, 3'b000);
    fetchDecode("sltu");
    step("sltu_execr", 1'b1, 1'b0, S_EXECR, ctl(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 4'b1001), 1'b0, 1'b0);
    step("sltu_aluwb", 1'b1, 1'b0, S_ALUWB, ctl(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 4'b0000), 1'b0, 1'b0);

    setInstr(OP_IMM, 3'b101, 1'b1, 3'b000);
    fetchDecode("srai");
    step("srai_execi", 1'b1, 1'b0, S_EXECI, ctl(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 4'b1000), 1'b0, 1'b0);
    step("srai_aluwb", 1'b1, 1'b0, S_ALUWB, ctl(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 4'b0000), 1'b0, 1'b0);

    setInstr(OP_IMM, 3'b000, 1'b1, 3'b000);
    fetchDecode("addi");
    step("addi_execi", 1'b1, 1'b0, S_EXECI, ctl(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 4'b0000), 1'b0, 1'b0);
    step("addi_aluwb", 1'b1, 1'b0, S_ALUWB, ctl(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 4'b0000), 1'b0, 1'b0);

    setInstr(OP_LOAD, 3'b010, 1'b0, 3'b000);
    fetchDecode("lw");
    step("lw_memadr", 1'b1, 1'b0, S_MEMADR, ctl(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 4'b0000), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step("lw_memread_wait", 1'b0, 1'b0, S_MEMREAD, ctl(1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'b0000), 1'b0, 1'b0);
    step("lw_memread_done", 1'b1, 1'b0, S_MEMREAD, ctl(1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'b0000), 1'b0, 1'b0);
    step("lw_memwb", 1'b0, 1'b0, S_MEMWB, ctl(0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 4'b0000), 1'b0, 1'b0);

    setInstr(OP_BRANCH, 3'b000, 1'b0, 3'b010);
    fetchDecode("beq");
    step("beq_taken", 1'b1, 1'b1, S_BRANCH, ctl(0, 0, 0, 0, 1, 0, 2'b00, 2'b10, 2'b00, 4'b0001), 1'b0, 1'b0);

    setInstr(OP_BRANCH, 3'b001, 1'b0, 3'b010);
    fetchDecode("bne_z1");
    step("bne_not_taken", 1'b1, 1'b1, S_BRANCH, ctl(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 4'b0001), 1'b0, 1'b0);
    fetchDecode("bne_z0");
    step("bne_taken", 1'b1, 1'b0, S_BRANCH, ctl(0, 0, 0, 0, 1, 0, 2'b00, 2'b10, 2'b00, 4'b0001), 1'b0, 1'b0);

    setInstr(OP_JALR, 3'b000, 1'b0, 3'b000);
    fetchDecode("jalr");
    step("jalr_adr", 1'b1, 1'b0, S_JALRADR, ctl(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 4'b0000), 1'b0, 1'b0);
    step("jalr_jal", 1'b1, 1'b0, S_JAL, ctl(0, 0, 0, 0, 1, 0, 2'b00, 2'b01, 2'b10, 4'b0000), 1'b0, 1'b0);
    step("jalr_aluwb", 1'b1, 1'b0, S_ALUWB, ctl(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 4'b0000), 1'b0, 1'b0);

    setInstr(OP_JAL, 3'b000, 1'b0, 3'b011);
    fetchDecode("jal");
    step("jal_jal", 1'b1, 1'b0, S_JAL, ctl(0, 0, 0, 0, 1, 0, 2'b00, 2'b01, 2'b10, 4'b0000), 1'b0, 1'b0);
    step("jal_aluwb", 1'b1, 1'b0, S_ALUWB, ctl(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 4'b0000), 1'b0, 1'b0);

    setInstr(OP_LUI, 3'b000, 1'b0, 3'b100);
    fetchDecode("lui");
    step("lui_lui", 1'b1, 1'b0, S_LUI, ctl(0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 2'b01, 4'b0000), 1'b0, 1'b0);
    step("lui_aluwb", 1'b1, 1'b0, S_ALUWB, ctl(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 4'b0000), 1'b0, 1'b0);

    setInstr(OP_STORE, 3'b010, 1'b0, 3'b001);
    fetchDecode("sw");
    step("sw_memadr", 1'b1, 1'b0, S_MEMADR, ctl(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 4'b0000), 1'b0, 1'b0);
    step("sw_wait", 1'b0, 1'b0, S_MEMWRITE, ctl(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'b0000), 1'b0, 1'b0);
    step("sw_commit", 1'b1, 1'b0, S_MEMWRITE, ctl(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'b0000), 1'b0, 1'b0);

    setInstr(OP_BRANCH, 3'b010, 1'b0, 3'b010);
    fetchDecode("badbr");
    step("badbr_trap", 1'b0, 1'b0, S_TRAP, 16'h0000, 1'b1, 1'b0);
    step("badbr_trap_hold", 1'b1, 1'b1, S_TRAP, 16'h0000, 1'b1, 1'b0);
    pulseReset("badbr_rst");

    setInstr(OP_RTYPE, 3'b000, 1'b0, 3'b000);
    for (int i = 0; i < 4; i++)
      step("tmo_fetch_wait", 1'b0, 1'b0, S_FETCH, ctl(1, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 4'b0000), 1'b0, 1'b0);
    step("tmo_trap", 1'b1, 1'b0, S_TRAP, 16'h0000, 1'b0, 1'b1);
    step("tmo_trap_hold", 1'b0, 1'b0, S_TRAP, 16'h0000, 1'b0, 1'b1);
    pulseReset("tmo_rst");

    setInstr(OP_STORE, 3'b010, 1'b0, 3'b001);
    for (int i = 0; i < 3; i++)
      step("late_fetch_wait", 1'b0, 1'b0, S_FETCH, ctl(1, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 4'b0000), 1'b0, 1'b0);
    step("late_fetch_ready", 1'b1, 1'b0, S_FETCH, ctl(1, 0, 0, 1, 1, 0, 2'b10, 2'b00, 2'b10, 4'b0000), 1'b0, 1'b0);
    step("late_decode", 1'b1, 1'b0, S_DECODE, ctl(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 4'b0000), 1'b0, 1'b0);
    step("late_memadr", 1'b1, 1'b0, S_MEMADR, ctl(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 4'b0000), 1'b0, 1'b0);
    applyStimulus("midsw_wait", 1'b0, 1'b0, S_MEMWRITE, ctl(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'b0000), 1'b0, 1'b0);
    #1;
    checkOutput();
    pulseReset("midsw_rst");
    step("post_rst_fetch", 1'b1, 1'b0, S_FETCH, ctl(1, 0, 0, 1, 1, 0, 2'b10, 2'b00, 2'b10, 4'b0000), 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
